ram_responder: RTL and testbench

Memory-side responder for the processor datapath's RAM interface. It serves instruction fetches and data reads and writes from one unified word array over a shared address bus, with a request/acknowledge handshake and a configurable number of wait states. It sits between the datapath (address from the PC or IR mux, write data from the ALU/data mux) and the storage. Data requests take priority over instruction fetches.

---
 rtl/ram_responder.sv | 153 +++++++++++++++
 tb/tb_ram_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Unified instruction/data RAM responder with request/ack handshake and a
// fixed number of wait states. Data requests win over instruction fetches.
module ram_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int INST_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 2**ADDR_WIDTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_N,
    input  logic [ADDR_WIDTH-1:0] Ram_Addr,
    input  logic [DATA_WIDTH-1:0] Ram_Data_In,
    input  logic                  Inst_Req,
    input  logic                  Data_Rd_Req,
    input  logic                  Data_Wr_Req,
    output logic [INST_WIDTH-1:0] Ram_Inst_Out,
    output logic [DATA_WIDTH-1:0] Ram_Data_Out,
    output logic                  Ram_Ack,
    output logic                  Ram_Busy,
    output logic                  Ram_Err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE, OP_BOTH} op_t;

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state_q, state_d;
    op_t                     op_q, op_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [INST_WIDTH-1:0]   inst_out_q, inst_out_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    op_t                     req_op;
    logic                    accept;
    logic                    access;
    op_t                     acc_op;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_data;
    logic [IDX_W-1:0]        acc_idx;
    logic                    acc_err;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_comb begin
        if (Data_Rd_Req && Data_Wr_Req) req_op = OP_BOTH;
        else if (Data_Wr_Req)           req_op = OP_WRITE;
        else if (Data_Rd_Req)           req_op = OP_READ;
        else                            req_op = OP_FETCH;
    end

    assign accept = (state_q == S_IDLE) && (Inst_Req || Data_Rd_Req || Data_Wr_Req);
    assign access = ((state_q == S_WAIT) && (cnt_q == 4'd0)) ||
                    (accept && (WAIT_CYCLES == 0));

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live inputs stand in for the not-yet-latched copies.
    assign acc_op   = (state_q == S_IDLE) ? req_op      : op_q;
    assign acc_addr = (state_q == S_IDLE) ? Ram_Addr    : addr_q;
    assign acc_data = (state_q == S_IDLE) ? Ram_Data_In : wdata_q;
    assign acc_idx  = acc_addr[IDX_W-1:0];
    assign acc_err  = (acc_op == OP_BOTH) || ({1'b0, acc_addr} >= DEPTH_W);
    assign mem_we   = Rst_N && access && !acc_err && (acc_op == OP_WRITE);
    assign rd_word  = mem[acc_idx];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        inst_out_d = inst_out_q;
        data_out_d = data_out_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = Ram_Addr;
                    wdata_d = Ram_Data_In;
                    op_d    = req_op;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (access && !acc_err) begin
            if (acc_op == OP_READ)  data_out_d = rd_word;
            if (acc_op == OP_FETCH) inst_out_d = rd_word[INST_WIDTH-1:0];
        end

        ack_d  = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
        err_d  = access && acc_err;
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q    <= S_IDLE;
            op_q       <= OP_FETCH;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            inst_out_q <= '0;
            data_out_q <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            inst_out_q <= inst_out_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge Clk) begin
        if (mem_we) mem[acc_idx] <= acc_data;
    end

    assign Ram_Inst_Out = inst_out_q;
    assign Ram_Data_Out = data_out_q;
    assign Ram_Ack      = ack_q;
    assign Ram_Busy     = busy_q;
    assign Ram_Err      = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three configurations (2 wait states, DEPTH=200,
// zero wait states) driven from one vector table with a result scoreboard.
module tb_ram_responder;

    localparam int NDUT = 3;

    typedef struct {
        int          k;
        logic        inst;
        logic        rd;
        logic        wr;
        logic        hold;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic [15:0] exp_inst;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [15:0] inst;
        logic        err;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n    [NDUT];
    logic [7:0]  addr     [NDUT];
    logic [15:0] wdata    [NDUT];
    logic        inst_req [NDUT];
    logic        rd_req   [NDUT];
    logic        wr_req   [NDUT];
    logic [15:0] inst_out [NDUT];
    logic [15:0] data_out [NDUT];
    logic        ack      [NDUT];
    logic        busy     [NDUT];
    logic        err      [NDUT];

    int   checks = 0;
    int   errors = 0;
    sb_t  sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    ram_responder #(.WAIT_CYCLES(2)) dut0 (
        .Clk(clk), .Rst_N(rst_n[0]), .Ram_Addr(addr[0]), .Ram_Data_In(wdata[0]),
        .Inst_Req(inst_req[0]), .Data_Rd_Req(rd_req[0]), .Data_Wr_Req(wr_req[0]),
        .Ram_Inst_Out(inst_out[0]), .Ram_Data_Out(data_out[0]),
        .Ram_Ack(ack[0]), .Ram_Busy(busy[0]), .Ram_Err(err[0])
    );

    ram_responder #(.WAIT_CYCLES(2), .DEPTH(200)) dut1 (
        .Clk(clk), .Rst_N(rst_n[1]), .Ram_Addr(addr[1]), .Ram_Data_In(wdata[1]),
        .Inst_Req(inst_req[1]), .Data_Rd_Req(rd_req[1]), .Data_Wr_Req(wr_req[1]),
        .Ram_Inst_Out(inst_out[1]), .Ram_Data_Out(data_out[1]),
        .Ram_Ack(ack[1]), .Ram_Busy(busy[1]), .Ram_Err(err[1])
    );

    ram_responder #(.WAIT_CYCLES(0)) dut2 (
        .Clk(clk), .Rst_N(rst_n[2]), .Ram_Addr(addr[2]), .Ram_Data_In(wdata[2]),
        .Inst_Req(inst_req[2]), .Data_Rd_Req(rd_req[2]), .Data_Wr_Req(wr_req[2]),
        .Ram_Inst_Out(inst_out[2]), .Ram_Data_Out(data_out[2]),
        .Ram_Ack(ack[2]), .Ram_Busy(busy[2]), .Ram_Err(err[2])
    );

    function automatic int waits_of(int k);
        return (k == 2) ? 0 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request at a negedge in IDLE; returns at the negedge of the
    // following IDLE cycle so the next request is accepted back-to-back.
    task automatic run_txn(input vec_t v);
        sb_t e;
        int  n = 0;
        int  busy_cnt = 0;
        int  ack_at = -1;
        int  k = v.k;
        addr[k]     = v.addr;
        wdata[k]    = v.wdata;
        inst_req[k] = v.inst;
        rd_req[k]   = v.rd;
        wr_req[k]   = v.wr;
        sb.push_back('{v.exp_data, v.exp_inst, v.exp_err});
        @(posedge clk);
        #1;
        addr[k]  = ~v.addr;
        wdata[k] = ~v.wdata;
        while (ack_at < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy[k]) busy_cnt++;
            if (ack[k])  ack_at = n;
        end
        e = sb.pop_front();
        if (ack_at < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout dut%0d: got no ack expected ack within 40 cycles", k);
        end else begin
            check("ack_cycle",   ack_at,      waits_of(k) + 1);
            check("busy_cycles", busy_cnt,    waits_of(k) + 1);
            check("err",         err[k],      e.err);
            check("data_out",    data_out[k], e.data);
            check("inst_out",    inst_out[k], e.inst);
        end
        rd_req[k]   = 1'b0;
        wr_req[k]   = 1'b0;
        inst_req[k] = v.hold;
        @(negedge clk);
        check("idle_busy", busy[k], 1'b0);
        check("idle_ack",  ack[k],  1'b0);
        $display("txn dut%0d addr=%02h inst=%b rd=%b wr=%b wdata=%04h -> data=%04h inst=%04h err=%b ack_cycle=%0d",
                 k, v.addr, v.inst, v.rd, v.wr, v.wdata, data_out[k], inst_out[k], e.err, ack_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected simulation end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              k inst rd wr hold addr   wdata     exp_data  exp_inst  err
        vecs.push_back('{0, 0, 0, 1, 0, 8'h10, 16'hBEEF, 16'h0000, 16'h0000, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 8'h10, 16'h0000, 16'hBEEF, 16'h0000, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 8'h10, 16'h0000, 16'hBEEF, 16'hBEEF, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 8'h20, 16'h1357, 16'hBEEF, 16'hBEEF, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 8'h20, 16'h0000, 16'h1357, 16'hBEEF, 0});
        vecs.push_back('{0, 0, 1, 1, 0, 8'h10, 16'h5555, 16'h1357, 16'hBEEF, 1});
        vecs.push_back('{0, 0, 1, 0, 0, 8'h10, 16'h0000, 16'hBEEF, 16'hBEEF, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 8'hFF, 16'hA5A5, 16'hBEEF, 16'hBEEF, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 8'hFF, 16'h0000, 16'hBEEF, 16'hA5A5, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 8'h20, 16'h0000, 16'h1357, 16'hA5A5, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 8'h20, 16'h0000, 16'h1357, 16'h1357, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 8'h10, 16'h0000, 16'hBEEF, 16'h1357, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 8'h10, 16'h0000, 16'hBEEF, 16'hBEEF, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 8'h30, 16'h2468, 16'hBEEF, 16'hBEEF, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 8'h30, 16'h0000, 16'hBEEF, 16'h2468, 0});
        vecs.push_back('{1, 0, 0, 1, 0, 8'hC8, 16'h7777, 16'h0000, 16'h0000, 1});
        vecs.push_back('{1, 0, 0, 1, 0, 8'hC7, 16'h1111, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 8'hC7, 16'h0000, 16'h1111, 16'h0000, 0});
        vecs.push_back('{1, 0, 1, 0, 0, 8'hC8, 16'h0000, 16'h1111, 16'h0000, 1});
        vecs.push_back('{1, 1, 0, 0, 0, 8'hC8, 16'h0000, 16'h1111, 16'h0000, 1});
        vecs.push_back('{2, 0, 0, 1, 0, 8'h05, 16'hCAFE, 16'h0000, 16'h0000, 0});
        vecs.push_back('{2, 0, 1, 0, 0, 8'h05, 16'h0000, 16'hCAFE, 16'h0000, 0});
        vecs.push_back('{2, 1, 0, 0, 0, 8'h05, 16'h0000, 16'hCAFE, 16'hCAFE, 0});
        vecs.push_back('{2, 0, 1, 1, 0, 8'h05, 16'h9999, 16'hCAFE, 16'hCAFE, 1});

        for (int k = 0; k < NDUT; k++) begin
            rst_n[k]    = 1'b0;
            addr[k]     = '0;
            wdata[k]    = '0;
            inst_req[k] = 1'b0;
            rd_req[k]   = 1'b0;
            wr_req[k]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("reset_inst_out", inst_out[k], 16'h0000);
            check("reset_data_out", data_out[k], 16'h0000);
            check("reset_ack",      ack[k],      1'b0);
            check("reset_busy",     busy[k],     1'b0);
            check("reset_err",      err[k],      1'b0);
            rst_n[k] = 1'b1;
        end
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

        // Abort a write of 0x1234 to 0x10 during its first wait cycle.
        addr[0]   = 8'h10;
        wdata[0]  = 16'h1234;
        wr_req[0] = 1'b1;
        @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check("abort_inst_out", inst_out[0], 16'h0000);
        check("abort_data_out", data_out[0], 16'h0000);
        check("abort_ack",      ack[0],      1'b0);
        check("abort_busy",     busy[0],     1'b0);
        check("abort_err",      err[0],      1'b0);
        $display("txn dut0 abort write 1234 @10 -> busy=%b data=%04h inst=%04h", busy[0], data_out[0], inst_out[0]);
        wr_req[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        run_txn('{0, 0, 1, 0, 0, 8'h10, 16'h0000, 16'hBEEF, 16'h0000, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
